// File: rtl/axil_pkg.sv
// Shared AXI-Lite master package.
// FSM encodings, response codes, clog2.
package axil_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ADDR = 4'b0010,
    ST_RESP = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axil_master_arb_if.sv
// AXI-Lite bus bundle.
// master drives addr/data/valid, slave drives ready/resp.
interface axil_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_master_arb_rr_arbiter.sv
// Combinational round-robin picker.
// Searches from ptr+1 with wrap; one-hot + index.
module rr_arbiter
  import axil_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  // first requester after the pointer wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/axil_master_arb.sv
// Round-robin sequencer sharing one AXI-Lite master.
// One transaction in flight; timeout aborts hung slaves.
module axil_master_arb
  import axil_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_WIDTH  = 12,
  parameter  int DATA_WIDTH  = 32,
  parameter  int TIMEOUT_CYC = 255,
  localparam int IW = clog2(NUM_REQ),
  localparam int TW = clog2(TIMEOUT_CYC + 1) + 1,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                           axil_aclk,
  input  logic                           axil_aresetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [IW-1:0]                  grant_id,
  axil_if.master                         m_axil
);

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           gid_q, gid_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    awv_q, awv_d;
  logic                    wv_q, wv_d;
  logic                    arv_q, arv_d;
  logic                    brdy_q, brdy_d;
  logic                    rrdy_q, rrdy_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    tmo;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign aw_ok = !awv_q || m_axil.awready;
  assign w_ok  = !wv_q || m_axil.wready;
  assign tmo   = (TIMEOUT_CYC != 0) &&
                 (tcnt_q >= TW'(TIMEOUT_CYC - 1));

  // next-state, handshake and completion logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    arv_d   = arv_q;
    brdy_d  = brdy_q;
    rrdy_d  = rrdy_q;
    busy_d  = busy_q;
    ack_d   = '0;
    rdata_d = '0;
    err_d   = 1'b0;
    tcnt_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gid_d   = arb_idx;
          gnt_d   = arb_gnt;
          wr_d    = req_write[arb_idx];
          addr_d  = req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
          awv_d   = req_write[arb_idx];
          wv_d    = req_write[arb_idx];
          arv_d   = !req_write[arb_idx];
          busy_d  = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        tcnt_d = (TIMEOUT_CYC == 0) ? '0 : tcnt_q + 1'b1;
        if (wr_q) begin
          awv_d = awv_q && !m_axil.awready;
          wv_d  = wv_q && !m_axil.wready;
          if (aw_ok && w_ok) begin
            brdy_d  = 1'b1;
            state_d = ST_RESP;
          end
        end else begin
          arv_d = arv_q && !m_axil.arready;
          if (m_axil.arready) begin
            rrdy_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
        if (tmo && state_d == ST_ADDR) begin
          awv_d   = 1'b0;
          wv_d    = 1'b0;
          arv_d   = 1'b0;
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_RESP: begin
        tcnt_d = (TIMEOUT_CYC == 0) ? '0 : tcnt_q + 1'b1;
        if (wr_q && m_axil.bvalid) begin
          brdy_d  = 1'b0;
          ack_d   = gnt_q;
          err_d   = m_axil.bresp != RESP_OKAY;
          state_d = ST_DONE;
        end else if (!wr_q && m_axil.rvalid) begin
          rrdy_d  = 1'b0;
          ack_d   = gnt_q;
          rdata_d = m_axil.rdata;
          err_d   = m_axil.rresp != RESP_OKAY;
          state_d = ST_DONE;
        end else if (tmo) begin
          brdy_d  = 1'b0;
          rrdy_d  = 1'b0;
          ack_d   = gnt_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = gid_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
    if (!axil_aresetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      brdy_q  <= 1'b0;
      rrdy_q  <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      brdy_q  <= brdy_d;
      rrdy_q  <= rrdy_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign m_axil.awaddr  = addr_q;
  assign m_axil.awvalid = awv_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = {SW{wv_q}};
  assign m_axil.wvalid  = wv_q;
  assign m_axil.bready  = brdy_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arvalid = arv_q;
  assign m_axil.rready  = rrdy_q;

  assign req_ack   = ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_axil_master_arb.sv
// Randomized bench for axil_master_arb.
// Reactive slave plus round-robin reference model.
module tb_axil_master_arb;
  import axil_pkg::*;

  localparam int N   = 4;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      grant_id;

  axil_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axil_master_arb #(
    .NUM_REQ(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .axil_aclk    (clk),
    .axil_aresetn (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ack      (req_ack),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .grant_id     (grant_id),
    .m_axil       (axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester side
  logic            cmd_wr[N];
  logic [AW-1:0]   cmd_addr[N];
  logic [DW-1:0]   cmd_data[N];
  logic [N-1:0]    vld;
  logic [N-1:0]    vld_prev;
  int              rq_st[N];

  // current transaction as seen by the model
  bit              active;
  int              c_id, c_lat, hang;
  logic            c_wr;
  logic [AW-1:0]   c_addr;
  logic [DW-1:0]   c_data, c_rdata;
  logic [1:0]      c_resp;
  int              aw_wait, w_wait, ar_wait, r_wait;
  bit              aw_done, w_done, ar_done, rsp_given, zero;
  int              aw_n, w_n, ar_n, extra;

  int              last_g, g_cnt, acks, cyc;
  bit              busy_prev, rst_done, post_rst;

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic new_cmd(input int i, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_wr[i] = wr; cmd_addr[i] = a; cmd_data[i] = d;
    rq_st[i] = 1; vld[i] = 1'b1;
  endtask

  task automatic rnd_cmd(input int i);
    new_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = vld[i];
      req_write[i] = cmd_wr[i];
      req_addr[i*AW +: AW]  = cmd_addr[i];
      req_wdata[i*DW +: DW] = cmd_data[i];
    end
  endtask

  task automatic s_idle();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_ctl"}, {req_ack, rsp_err, busy, grant_id, axi.awvalid,
        axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 64'h0);
    chk({p, "_rdata"}, rsp_rdata, 64'h0);
    chk({p, "_addr"}, {axi.awaddr, axi.araddr}, 64'h0);
    chk({p, "_wdata"}, {axi.wdata, axi.wstrb}, 64'h0);
  endtask

  task automatic pick_slave();
    aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
    hang = 0; c_resp = RESP_OKAY; c_rdata = $urandom;
    if (g_cnt == 0) c_rdata = 32'hDEADBEEF;
    else if (g_cnt == 1) aw_wait = 3;
    else if (g_cnt == 10) c_resp = RESP_SLVERR;
    else if (g_cnt == 11) hang = 1;
    else if (g_cnt > 11) begin
      aw_wait = $urandom_range(0, 3);
      w_wait  = $urandom_range(0, 3);
      ar_wait = $urandom_range(0, 3);
      r_wait  = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) c_resp = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) hang = $urandom_range(1, 2);
    end
    zero = (aw_wait + w_wait + ar_wait + r_wait == 0) && hang == 0;
    aw_done = 0; w_done = 0; ar_done = 0; rsp_given = 0;
    aw_n = 0; w_n = 0; ar_n = 0; extra = 0;
  endtask

  initial begin
    vld = '0;
    for (int i = 0; i < N; i++) begin
      cmd_wr[i] = 1'b0; cmd_addr[i] = '0; cmd_data[i] = '0; rq_st[i] = 0;
    end
    drive_req();
    s_idle();
    active = 0; last_g = N - 1; g_cnt = 0; acks = 0; cyc = 0;
    busy_prev = 0; rst_done = 0; post_rst = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    new_cmd(0, 1'b0, 12'h010, 32'h0);
    drive_req();
    vld_prev = vld;

    while (acks < 160 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (active) c_lat++;

      if (acks >= 100 && !rst_done && active && c_wr && axi.bready) begin
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        rst_done = 1; post_rst = 1; active = 0; last_g = N - 1;
        for (int i = 0; i < N; i++) begin
          vld[i] = 1'b1; rq_st[i] = 1;
        end
        s_idle();
        drive_req();
        @(negedge clk);
        rst_n = 1'b1;
        vld_prev = vld; busy_prev = 0;
        continue;
      end

      if (req_ack != '0) begin
        if (!active) chk("ack_unexpected", req_ack, 64'h0);
        else begin
          chk("ack_onehot", req_ack, 64'(1 << c_id));
          if (hang != 0) begin
            chk("tmo_err", rsp_err, 64'h1);
            chk("tmo_rdata", rsp_rdata, 64'h0);
            chk("tmo_lat", c_lat, TMO);
          end else begin
            chk("rsp_err", rsp_err, 64'(c_resp != 2'b00));
            if (!c_wr) chk("rsp_rdata", rsp_rdata, c_rdata);
            if (zero) chk("min_lat", c_lat, 2);
            chk("hs_counts", {8'(aw_n), 8'(w_n), 8'(ar_n)},
                c_wr ? 64'h010100 : 64'h000001);
          end
          chk("valid_after_hs", extra, 64'h0);
          chk("bus_quiet", {axi.awvalid, axi.wvalid, axi.arvalid,
              axi.bready, axi.rready}, 64'h0);
          active = 0; acks++;
          rq_st[c_id] = 0; vld[c_id] = 1'b0;
          if (acks == 1) new_cmd(1, 1'b1, 12'h008, 32'h12345678);
          else if (acks == 2) for (int i = 0; i < N; i++) rnd_cmd(i);
          else if (acks < 10 || $urandom_range(0, 1) == 0) rnd_cmd(c_id);
        end
      end

      if (busy && !busy_prev) begin
        int e;
        chk("overlap", active, 64'h0);
        e = rr_pick(last_g, vld_prev);
        chk("grant_id", grant_id, 64'(e));
        if (post_rst) begin
          chk("post_rst_first", grant_id, 64'h0);
          post_rst = 0;
        end
        if (e >= 0) begin
          active = 1; c_lat = 0; c_id = e; last_g = e;
          c_wr = cmd_wr[e]; c_addr = cmd_addr[e]; c_data = cmd_data[e];
          rq_st[e] = 2;
          pick_slave();
          g_cnt++;
          if (acks >= 10) begin
            if ($urandom_range(0, 7) == 0) vld[e] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
              cmd_addr[e] = AW'($urandom); cmd_data[e] = $urandom;
            end
          end
        end
      end

      if (active && c_lat > 40) begin
        chk("txn_stall", c_lat, 64'd40);
        active = 0;
      end

      s_idle();
      if (active && hang != 1) begin
        if (c_wr) begin
          if (axi.awvalid) begin
            if (aw_done) extra++;
            else if (aw_wait == 0) begin
              axi.awready = 1'b1; aw_done = 1; aw_n++;
              chk("awaddr", axi.awaddr, c_addr);
            end else aw_wait--;
          end
          if (axi.wvalid) begin
            if (w_done) extra++;
            else if (w_wait == 0) begin
              axi.wready = 1'b1; w_done = 1; w_n++;
              chk("wdata", {axi.wstrb, axi.wdata}, {4'hF, c_data});
            end else w_wait--;
          end
          if (axi.bready && hang != 2 && !rsp_given) begin
            if (r_wait == 0) begin
              axi.bvalid = 1'b1; axi.bresp = c_resp; rsp_given = 1;
            end else r_wait--;
          end
        end else begin
          if (axi.arvalid) begin
            if (ar_done) extra++;
            else if (ar_wait == 0) begin
              axi.arready = 1'b1; ar_done = 1; ar_n++;
              chk("araddr", axi.araddr, c_addr);
            end else ar_wait--;
          end
          if (axi.rready && hang != 2 && !rsp_given) begin
            if (r_wait == 0) begin
              axi.rvalid = 1'b1; axi.rresp = c_resp;
              axi.rdata = c_rdata; rsp_given = 1;
            end else r_wait--;
          end
        end
      end

      if (acks >= 10)
        for (int i = 0; i < N; i++)
          if (rq_st[i] == 0 && $urandom_range(0, 3) == 0) rnd_cmd(i);
      drive_req();
      vld_prev = vld;
      busy_prev = busy;
    end

    chk("reset_mid_write_seen", rst_done, 64'h1);
    chk("ack_total", acks >= 160, 64'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
